// File: rtl/fetch_pkg.sv
// Shared defaults and the redirect-target helper for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEF_PC_W       = 32'd8;
  localparam int unsigned DEF_INSTR_W    = 32'd8;
  localparam int unsigned DEF_OFFS_W     = 32'd6;
  localparam int unsigned DEF_FIFO_DEPTH = 32'd2;

  // Sign-extends an offs_w-bit offset and adds it to base; caller truncates to PC_W.
  function automatic logic [31:0] redirect_target(
    input logic [31:0] base,
    input logic [31:0] offset,
    input int unsigned offs_w
  );
    int unsigned sh;
    logic [31:0] shifted;
    logic [31:0] sext;
    sh      = 32'd32 - offs_w;
    shifted = offset << sh;
    sext    = $signed(shifted) >>> sh;
    return base + sext;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush; pointers wrap modulo DEPTH so any depth >= 2 works.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32'd16,
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PTR_W = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 32'd1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 32'd1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty   = (count == {CNT_W{1'b0}});
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy update; flush discards everything buffered.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {CNT_W{1'b0}};
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit_pipe.sv
// Instruction fetch stage: PC, credit-based issue to a 1-cycle imem, buffer and redirect flush.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit_pipe
  import fetch_pkg::*;
#(
  parameter int unsigned     PC_W       = DEF_PC_W,
  parameter int unsigned     INSTR_W    = DEF_INSTR_W,
  parameter int unsigned     OFFS_W     = DEF_OFFS_W,
  parameter int unsigned     FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC   = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_base,
  input  logic [OFFS_W-1:0]  redirect_offset,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [INSTR_W-1:0] fetch_instr,
  output logic [PC_W-1:0]    fetch_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [15:0]        perf_flushes
`endif
);

  localparam int unsigned ENTRY_W = PC_W + INSTR_W;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH + 32'd1);

  logic [PC_W-1:0]    pc_q;
  logic               inflight;
  logic [PC_W-1:0]    tag;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W:0]     demand;
  logic               issue;
  logic               pop;
  logic               push;
  logic [PC_W-1:0]    target;

  // The returning word counts against the credit so it always has a slot.
  assign demand = {1'b0, fifo_count} + (CNT_W + 1)'(inflight) - (CNT_W + 1)'(pop);
  assign issue  = ~reset & ~redirect_valid & (demand < (CNT_W + 1)'(FIFO_DEPTH));

  assign fetch_valid = ~reset & ~fifo_empty & ~redirect_valid;
  assign pop         = fetch_valid & fetch_ready;
  assign push        = inflight & ~redirect_valid;
  assign imem_en     = issue;
  assign imem_addr   = pc_q;
  assign target      = PC_W'(redirect_target(32'(redirect_base), 32'(redirect_offset), OFFS_W));

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({tag, imem_rdata}),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Head presentation; zeroed when nothing is buffered.
  always_comb begin
    fetch_instr = {INSTR_W{1'b0}};
    fetch_pc    = {PC_W{1'b0}};
    if (reset || fifo_empty) begin
      fetch_instr = {INSTR_W{1'b0}};
      fetch_pc    = {PC_W{1'b0}};
    end else begin
      fetch_instr = head[INSTR_W-1:0];
      fetch_pc    = head[ENTRY_W-1:INSTR_W];
    end
  end

  // PC and in-flight tracking; a redirect kills the pending return.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      inflight <= 1'b0;
      tag      <= {PC_W{1'b0}};
    end else if (redirect_valid) begin
      pc_q     <= target;
      inflight <= 1'b0;
      tag      <= tag;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc_q <= pc_q + PC_W'(1);
        tag  <= pc_q;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'd0;
      perf_flushes <= 16'd0;
    end else begin
      if (pop)            perf_fetched <= perf_fetched + 32'd1;
      if (redirect_valid) perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_unit_pipe.md
Name: fetch_unit_pipe

Overview:
Parametrised instruction fetch stage: holds the PC, issues addresses to a synchronous-read instruction memory, buffers returned words in a small FIFO and presents them to decode over a valid/ready handshake. It supports PC-relative redirects (jump/branch) that flush all in-flight and buffered instructions. It sits between the instruction memory and the decode stage and replaces the single-register fetch path.

Parameters:
PC_W, 8, PC / instruction address width in bits.
INSTR_W, 8, instruction word width.
OFFS_W, 6, signed redirect offset width; must be <= PC_W.
FIFO_DEPTH, 2, fetch buffer entries; must be >= 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
imem_en  out  1  read strobe; high when imem_addr is issued this cycle.
imem_addr  out  PC_W  read address.
imem_rdata  in  INSTR_W  data for the address issued in the previous cycle (fixed 1-cycle latency).
redirect_valid  in  1  take a redirect this cycle.
redirect_base  in  PC_W  PC of the redirecting instruction.
redirect_offset  in  OFFS_W  signed two's-complement offset.
fetch_valid  out  1  fetch_instr and fetch_pc are valid.
fetch_ready  in  1  decode accepts this cycle.
fetch_instr  out  INSTR_W  instruction word.
fetch_pc  out  PC_W  address of fetch_instr.

Behaviour:
- Reset: pc_q=RESET_PC, FIFO empty, in-flight flag cleared, imem_en=0, fetch_valid=0, fetch_instr=0, fetch_pc=0. Reset overrides redirect.
- Credit rule: issue when occupancy + inflight - pop < FIFO_DEPTH and redirect_valid=0. pop = fetch_valid & fetch_ready.
- On issue: imem_en=1, imem_addr=pc_q, pc_q <= pc_q+1 (mod 2^PC_W, wraps from all-ones to 0), inflight tag <= pc_q.
- Return: the cycle after an issue, {tag, imem_rdata} is pushed into the FIFO unless killed by a redirect.
- Output: fetch_valid = FIFO non-empty & ~redirect_valid. FIFO head drives fetch_instr/fetch_pc. There is no FIFO write-to-read bypass.
- Latency: reset deasserted before cycle 0 -> issue RESET_PC in cycle 0 -> data pushed at end of cycle 1 -> fetch_valid in cycle 2.
- Throughput: with FIFO_DEPTH>=2 and fetch_ready held high, 1 instruction/cycle sustained.
- Redirect (cycle t):
  - target = redirect_base + sign_extend(redirect_offset), truncated to PC_W (wraps both directions).
  - FIFO cleared, in-flight return discarded, no issue in cycle t, pc_q <= target.
  - A handshake in cycle t cannot occur because fetch_valid is forced 0.
  - Target is issued in t+1 and is visible on fetch_valid in t+3.
  - Back-to-back redirects: each one re-flushes; only the last target survives.
- Backpressure: when fetch_ready=0, the FIFO fills and then issue stops. The in-flight word always has a reserved slot, so there is no overflow and no word is ever dropped or duplicated.
- Simultaneous push and pop: both happen and occupancy is unchanged. A pop on an empty FIFO cannot occur.

Optional Feature:
FETCH_PERF_CNT_EN:
- When defined, adds outputs perf_fetched (32-bit; counts fetch_valid&fetch_ready handshakes) and perf_flushes (16-bit; counts redirect_valid cycles).
- Both counters wrap, and reset clears them to 0.
- When undefined, these ports and their logic are absent, and the remaining behaviour is identical.

Decomposition:
- Package fetch_pkg: default width localparams and a redirect-target function (sign-extend plus add, truncated to PC_W).
- Sub-module fetch_fifo: synchronous FIFO, width PC_W+INSTR_W, depth FIFO_DEPTH, with push/pop/flush and count outputs. Pointers wrap modulo FIFO_DEPTH, so non-power-of-2 depths are legal.
- Top level: PC register, credit logic, in-flight tag and kill.

Test Plan:
- Reset then fetch_ready=1, memory returns word=addr^8'hA5 -> fetch_pc 0,1,2,... from cycle 2, one per cycle, instr matching.
- Sequential fetch past 8'hFF -> fetch_pc 8'hFE, 8'hFF, 8'h00 in order, with no gap.
- fetch_ready=0 for 10 cycles -> exactly FIFO_DEPTH entries held and imem_en low; on release, order is kept with no loss or duplicate.
- redirect base=8'h10, offset=6'h3C (-4) -> flush, next fetch_pc=8'h0C appears 3 cycles later; base=8'hFE, offset=+5 -> 8'h03.
- Redirect in the same cycle as the in-flight return and with fetch_ready=1 -> no stale pc accepted, and fetch_valid=0 that cycle.
- Reset asserted mid-stream with a full FIFO -> next cycle fetch_valid=0 and the sequence restarts at RESET_PC; with FETCH_PERF_CNT_EN, the counters read 0.
